// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the tile draw arbiter: FSM state encoding,
// pixel-port widths and the per-requester draw payload.
package gfx_pkg;

    localparam int unsigned COLOUR_W   = 3;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned TILE_NUM_W = 2;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

    // Draw sequence of one granted request.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DRAW = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Fields a requester presents alongside its req level.
    typedef struct packed {
        logic [TILE_NUM_W-1:0] tile;    // [0]=grid column, [1]=grid row
        logic [COLOUR_W-1:0]   colour;
        logic                  hold;
    } draw_req_t;

endpackage

// File: rtl/tile_pixel_sweep.sv
// Row-major pixel counter for one tile.
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_clr           force counter to pixel 0
//   i_en            advance one pixel (wraps after the last one)
//   o_col, o_row    current pixel column / row inside the tile
//   o_last          current pixel is the bottom-right one
module tile_pixel_sweep #(
    parameter int unsigned COL_W = 3,
    parameter int unsigned ROW_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last
);

    localparam int unsigned CNT_W = COL_W + ROW_W;

    logic [CNT_W-1:0] r_pix_cnt;

    // Pixel counter; natural wrap returns it to 0 after the last pixel.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pix_cnt <= '0;
        end else if (i_clr) begin
            r_pix_cnt <= '0;
        end else if (i_en) begin
            r_pix_cnt <= r_pix_cnt + CNT_W'(1);
        end
    end

    // Low bits select the column, so the sweep is row-major.
    assign o_col  = r_pix_cnt[COL_W-1:0];
    assign o_row  = r_pix_cnt[CNT_W-1:COL_W];
    assign o_last = &r_pix_cnt;

endmodule

// File: rtl/tile_draw_arbiter.sv
// Shares the VGA pixel-write port between two tile-drawing requesters.
// Each granted request paints one TILE_W x TILE_H tile of a 2x2 grid, then
// optionally holds the port for DELAY_CYCLES before pulsing its done.
// Build option: define TILE_ARB_BORDER_EN to draw edge pixels of every tile
// in black (same timing and pixel count).
// Ports:
//   clock, resetn         clock, synchronous active-low reset
//   req0/req1             draw request level, held until done
//   tile0/tile1           tile number ([0]=column, [1]=row)
//   colour0/colour1       fill colour
//   hold0/hold1           apply post-draw hold
//   done0/done1           one-cycle completion pulse to the granted requester
//   x, y, colour          pixel coordinates and colour
//   writeEnable           pixel write strobe
//   busy                  high whenever not idle
module tile_draw_arbiter
    import gfx_pkg::*;
#(
    parameter int unsigned TILE_W       = 8,
    parameter int unsigned TILE_H       = 8,
    parameter int unsigned X0           = 40,
    parameter int unsigned Y0           = 20,
    parameter int unsigned STRIDE       = 40,
    parameter int unsigned DELAY_CYCLES = 25000000
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [TILE_NUM_W-1:0] tile0,
    input  logic [TILE_NUM_W-1:0] tile1,
    input  logic [COLOUR_W-1:0]   colour0,
    input  logic [COLOUR_W-1:0]   colour1,
    input  logic                  hold0,
    input  logic                  hold1,
    output logic                  done0,
    output logic                  done1,
    output logic [X_W-1:0]        x,
    output logic [Y_W-1:0]        y,
    output logic [COLOUR_W-1:0]   colour,
    output logic                  writeEnable,
    output logic                  busy
);

    localparam int unsigned COL_W = $clog2(TILE_W);
    localparam int unsigned ROW_W = $clog2(TILE_H);
    localparam int unsigned DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYCLES - 1);

    localparam logic [X_W-1:0] X_BASE0 = X_W'(X0);
    localparam logic [X_W-1:0] X_BASE1 = X_W'(X0 + STRIDE);
    localparam logic [Y_W-1:0] Y_BASE0 = Y_W'(Y0);
    localparam logic [Y_W-1:0] Y_BASE1 = Y_W'(Y0 + STRIDE);

    state_t              r_state;
    state_t              w_next;
    logic                r_last_grant;
    logic                w_grant;
    draw_req_t           w_win_req;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_hold;
    logic [X_W-1:0]      r_x_base;
    logic [Y_W-1:0]      r_y_base;
    logic [DLY_W-1:0]    r_dly;
    logic                r_we;
    logic                r_busy;
    logic                r_done0;
    logic                r_done1;
    logic [COL_W-1:0]    w_col;
    logic [ROW_W-1:0]    w_row;
    logic                w_last;

    // Pixel position inside the tile.
    tile_pixel_sweep #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_sweep (
        .i_clk   (clock),
        .i_rst_n (resetn),
        .i_clr   (r_state == ST_LOAD),
        .i_en    (r_state == ST_DRAW),
        .o_col   (w_col),
        .o_row   (w_row),
        .o_last  (w_last)
    );

    // Payload of the requester that currently owns the grant.
    assign w_win_req = r_last_grant
                     ? '{tile: tile1, colour: colour1, hold: hold1}
                     : '{tile: tile0, colour: colour0, hold: hold0};

    // Next state and round-robin arbitration (grant decided only in IDLE).
    always_comb begin
        w_next  = r_state;
        w_grant = r_last_grant;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_grant = ~r_last_grant;
                end else if (req0) begin
                    w_grant = 1'b0;
                end else if (req1) begin
                    w_grant = 1'b1;
                end
                if (req0 || req1) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_next = ST_DRAW;
            end
            ST_DRAW: begin
                if (w_last) begin
                    w_next = r_hold ? ST_HOLD : ST_DONE;
                end
            end
            ST_HOLD: begin
                if (r_dly == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state,
    // so they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= (w_next == ST_DRAW);
            r_busy  <= (w_next != ST_IDLE);
            r_done0 <= (w_next == ST_DONE) && !r_last_grant;
            r_done1 <= (w_next == ST_DONE) &&  r_last_grant;
        end
    end

    // Grant history and per-draw latches; the latches alone drive x/y/colour.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
            r_colour     <= '0;
            r_hold       <= 1'b0;
            r_x_base     <= '0;
            r_y_base     <= '0;
        end else begin
            if ((r_state == ST_IDLE) && (w_next == ST_LOAD)) begin
                r_last_grant <= w_grant;
            end
            if (r_state == ST_LOAD) begin
                r_colour <= w_win_req.colour;
                r_hold   <= w_win_req.hold;
                r_x_base <= w_win_req.tile[0] ? X_BASE1 : X_BASE0;
                r_y_base <= w_win_req.tile[1] ? Y_BASE1 : Y_BASE0;
            end
        end
    end

    // Post-draw hold counter: armed on the last pixel, counts down to 0 in HOLD.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_dly <= '0;
        end else if ((r_state == ST_DRAW) && w_last) begin
            r_dly <= DLY_LOAD;
        end else if ((r_state == ST_HOLD) && (r_dly != '0)) begin
            r_dly <= r_dly - DLY_W'(1);
        end
    end

    assign x           = r_x_base + X_W'(w_col);
    assign y           = r_y_base + Y_W'(w_row);
    assign writeEnable = r_we;
    assign busy        = r_busy;
    assign done0       = r_done0;
    assign done1       = r_done1;

`ifdef TILE_ARB_BORDER_EN
    logic w_edge;

    // Outline pixels on the tile perimeter.
    assign w_edge = (w_col == '0) || (w_col == COL_W'(TILE_W - 1)) ||
                    (w_row == '0) || (w_row == ROW_W'(TILE_H - 1));
    assign colour = ((r_state == ST_DRAW) && w_edge) ? BLACK : r_colour;
`else
    assign colour = r_colour;
`endif

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// Self-checking bench for tile_draw_arbiter with a short hold (DELAY_CYCLES=4).
module tb_tile_draw_arbiter;

    localparam int TW     = 8;
    localparam int TH     = 8;
    localparam int NPIX   = TW * TH;
    localparam int X0     = 40;
    localparam int Y0     = 20;
    localparam int STRIDE = 40;
    localparam int DLY    = 4;
`ifdef TILE_ARB_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       clock;
    logic       resetn;
    logic       req0, req1;
    logic [1:0] tile0, tile1;
    logic [2:0] colour0, colour1;
    logic       hold0, hold1;
    logic       done0, done1;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEnable;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int m_last   = 1;   // reference round-robin history
    int n_writes;
    int n_black;
    int n_col7;

    tile_draw_arbiter #(
        .TILE_W       (TW),
        .TILE_H       (TH),
        .X0           (X0),
        .Y0           (Y0),
        .STRIDE       (STRIDE),
        .DELAY_CYCLES (DLY)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .req0        (req0),
        .req1        (req1),
        .tile0       (tile0),
        .tile1       (tile1),
        .colour0     (colour0),
        .colour1     (colour1),
        .hold0       (hold0),
        .hold1       (hold1),
        .done0       (done0),
        .done1       (done1),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .writeEnable (writeEnable),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic raise(input int who);
        if (who == 0) begin
            tile0 = 2'($urandom()); colour0 = 3'($urandom()); hold0 = 1'($urandom()); req0 = 1'b1;
        end else begin
            tile1 = 2'($urandom()); colour1 = 3'($urandom()); hold1 = 1'($urandom()); req1 = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_we", writeEnable, 0);
            check_eq("idle_done0", done0, 0);
            check_eq("idle_done1", done1, 0);
        end
    endtask

    // Called at a negedge in IDLE with at least one req high. Cycle c=0 is this
    // IDLE cycle; the expected timeline is LOAD at 1, NPIX writes from 2, an
    // optional DLY-cycle hold, then done. abort_c pulls reset at that cycle,
    // raise_c raises the losing requester mid-transaction if it is idle.
    task automatic run_txn(input int abort_c, input int raise_c, output int obs);
        int w, h, total, k, ex, ey, ec, col, row;
        logic [1:0] t;
        logic [2:0] cl;
        obs = -1;
        n_writes = 0; n_black = 0; n_col7 = 0;
        if (req0 && req1) w = (m_last == 1) ? 0 : 1;
        else if (req0)    w = 0;
        else              w = 1;
        m_last = w;
        t  = (w == 0) ? tile0 : tile1;
        cl = (w == 0) ? colour0 : colour1;
        h  = (w == 0) ? int'(hold0) : int'(hold1);
        total = 2 + NPIX + h * DLY;
        for (int c = 0; c <= total; c++) begin
            if (c > 0) @(negedge clock);
            check_eq("busy", busy, (c != 0) ? 1 : 0);
            check_eq("we", writeEnable, (c >= 2 && c < 2 + NPIX) ? 1 : 0);
            check_eq("done0", done0, (c == total && w == 0) ? 1 : 0);
            check_eq("done1", done1, (c == total && w == 1) ? 1 : 0);
            if (done0) obs = 0;
            if (done1) obs = 1;
            if (writeEnable) begin
                n_writes++;
                if (colour == 3'd0) n_black++;
                if (colour == 3'd7) n_col7++;
            end
            if (c >= 2 && c < 2 + NPIX) begin
                k   = c - 2;
                col = k % TW;
                row = k / TW;
                ex  = X0 + int'(t[0]) * STRIDE + col;
                ey  = Y0 + int'(t[1]) * STRIDE + row;
                ec  = (BORDER && (col == 0 || col == TW-1 || row == 0 || row == TH-1)) ? 0 : int'(cl);
                check_eq("x", x, ex);
                check_eq("y", y, ey);
                check_eq("colour", colour, ec);
            end
            if (c == raise_c) begin
                if (w == 0 && !req1) raise(1);
                if (w == 1 && !req0) raise(0);
            end
            if (c == abort_c) begin
                resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
                @(negedge clock);
                check_eq("rst_busy", busy, 0);
                check_eq("rst_we", writeEnable, 0);
                check_eq("rst_done0", done0, 0);
                check_eq("rst_done1", done1, 0);
                check_eq("rst_x", x, 0);
                check_eq("rst_y", y, 0);
                check_eq("rst_colour", colour, 0);
                resetn = 1'b1;
                m_last = 1;
                return;
            end
            if (c == total) begin
                if (w == 0) req0 = 1'b0; else req1 = 1'b0;
            end
        end
        check_eq("writes", n_writes, NPIX);
        @(negedge clock);
    endtask

    initial begin
        int obs;
        resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        tile0 = '0; tile1 = '0; colour0 = '0; colour1 = '0; hold0 = 1'b0; hold1 = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_we", writeEnable, 0);
        check_eq("reset_done0", done0, 0);
        check_eq("reset_done1", done1, 0);
        check_eq("reset_x", x, 0);
        check_eq("reset_y", y, 0);
        check_eq("reset_colour", colour, 0);
        resetn = 1'b1;
        m_last = 1;
        idle_cycles(2);

        // Single requester, tile 0, no hold.
        tile0 = 2'b00; colour0 = 3'b100; hold0 = 1'b0; req0 = 1'b1;
        run_txn(-1, -1, obs);
        check_eq("t1_grant", obs, 0);
        idle_cycles(2);

        // Single requester, tile 3, with hold.
        tile1 = 2'b11; colour1 = 3'b010; hold1 = 1'b1; req1 = 1'b1;
        run_txn(-1, -1, obs);
        check_eq("t2_grant", obs, 1);
        idle_cycles(1);

        // Simultaneous requests straight after reset: req0 first.
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        m_last = 1;
        tile0 = 2'b01; colour0 = 3'b011; hold0 = 1'b0;
        tile1 = 2'b10; colour1 = 3'b101; hold1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        run_txn(-1, -1, obs);
        check_eq("t3_first", obs, 0);
        run_txn(-1, -1, obs);
        check_eq("t3_second", obs, 1);

        // Both re-asserted after every done: grants alternate.
        for (int i = 0; i < 4; i++) begin
            if (!req0) raise(0);
            if (!req1) raise(1);
            run_txn(-1, -1, obs);
            check_eq("t4_alt", obs, i % 2);
        end
        while (req0 || req1) run_txn(-1, -1, obs);
        idle_cycles(1);

        // Reset during the 30th DRAW cycle.
        tile0 = 2'b10; colour0 = 3'b110; hold0 = 1'b1; req0 = 1'b1;
        run_txn(31, -1, obs);
        check_eq("t5_no_done", obs, -1);
        idle_cycles(3);

        // White tile: count outline pixels.
        tile0 = 2'b01; colour0 = 3'b111; hold0 = 1'b0; req0 = 1'b1;
        run_txn(-1, -1, obs);
        check_eq("t6_black", n_black, BORDER ? 28 : 0);
        check_eq("t6_white", n_col7, BORDER ? 36 : 64);
        idle_cycles(1);

        // Randomized traffic, including requests raised while busy.
        for (int i = 0; i < 40; i++) begin
            if (!req0 && !req1) begin
                idle_cycles($urandom_range(0, 2));
                case ($urandom_range(0, 2))
                    0:       raise(0);
                    1:       raise(1);
                    default: begin raise(0); raise(1); end
                endcase
            end else if ($urandom_range(0, 1) == 1) begin
                if (!req0) raise(0);
                if (!req1) raise(1);
            end
            run_txn(-1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 70)) : -1, obs);
        end
        while (req0 || req1) run_txn(-1, -1, obs);
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
